// File: rtl/mul_issue_if.sv
// Request/response and multiplier-core signal bundle for mul_issue_ctrl.
// The slave side is the controller; the master side is execute, the core and downstream.
interface mul_issue_if #(
  parameter int XLEN  = 64,
  parameter int TAG_W = 4
);
  logic             req_valid_i;
  logic             req_ready_o;
  logic [2:0]       req_op_i;
  logic [XLEN-1:0]  req_rs1_i;
  logic [XLEN-1:0]  req_rs2_i;
  logic [TAG_W-1:0] req_tag_i;
  logic             flush_i;
  logic             mul_datavaild_o;
  logic [XLEN-1:0]  multiplicand_o;
  logic [XLEN-1:0]  multiplier_o;
  logic             mul_ready_o;
  logic             mul_mulvalid_i;
  logic [XLEN-1:0]  result_hi_i;
  logic [XLEN-1:0]  result_lo_i;
  logic             rsp_valid_o;
  logic             rsp_ready_i;
  logic [XLEN-1:0]  rsp_data_o;
  logic [TAG_W-1:0] rsp_tag_o;
  logic             rsp_err_o;

  modport slave (
    input  req_valid_i, req_op_i, req_rs1_i, req_rs2_i, req_tag_i, flush_i,
           mul_mulvalid_i, result_hi_i, result_lo_i, rsp_ready_i,
    output req_ready_o, mul_datavaild_o, multiplicand_o, multiplier_o, mul_ready_o,
           rsp_valid_o, rsp_data_o, rsp_tag_o, rsp_err_o
  );

  modport master (
    output req_valid_i, req_op_i, req_rs1_i, req_rs2_i, req_tag_i, flush_i,
           mul_mulvalid_i, result_hi_i, result_lo_i, rsp_ready_i,
    input  req_ready_o, mul_datavaild_o, multiplicand_o, multiplier_o, mul_ready_o,
           rsp_valid_o, rsp_data_o, rsp_tag_o, rsp_err_o
  );
endinterface

// File: rtl/mul_issue_ctrl.sv
// Issue/retire controller in front of the pipelined 64x64 signed Booth multiplier core.
// Corrects high halves for the unsigned forms, sign-extends MULW, returns tagged results.
module mul_issue_ctrl #(
  parameter int XLEN    = 64,
  parameter int TAG_W   = 4,
  parameter int TIMEOUT = 16
) (
  input logic        clk,
  input logic        rst,
  mul_issue_if.slave bus
);
  // state | meaning
  // IDLE  | ready for a request; absorbs stale core results
  // ISSUE | operands presented to the core for one cycle
  // WAIT  | waiting for the core product, bounded by TIMEOUT
  // FIX   | high-half correction / word sign-extension
  // RESP  | response held until downstream accepts or flush
  // DRAIN | flushed request; consume the orphaned core result
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, FIX, RESP, DRAIN} state_t;

  localparam int CNT_W = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  localparam logic [2:0] OP_MUL    = 3'd0;
  localparam logic [2:0] OP_MULH   = 3'd1;
  localparam logic [2:0] OP_MULHSU = 3'd2;
  localparam logic [2:0] OP_MULHU  = 3'd3;
  localparam logic [2:0] OP_MULW   = 3'd4;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [XLEN-1:0]  a_q, b_q, hi_q, lo_q, data_q, fix_data;
  logic [2:0]       op_q;
  logic [TAG_W-1:0] tag_q;
  logic             err_q;
  logic             mul_ready, cnt_clr, cnt_inc, timeout, req_legal;

  assign timeout   = (cnt_q == CNT_LAST);
  assign req_legal = (bus.req_op_i <= OP_MULW);

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    mul_ready = 1'b0;
    cnt_clr   = 1'b0;
    cnt_inc   = 1'b0;
    case (state_q)
      IDLE: begin
        mul_ready = bus.mul_mulvalid_i;
        if (bus.req_valid_i) state_d = req_legal ? ISSUE : RESP;
      end
      ISSUE: begin
        cnt_clr = 1'b1;
        state_d = bus.flush_i ? DRAIN : WAIT;
      end
      WAIT: begin
        if (bus.mul_mulvalid_i) begin
          mul_ready = 1'b1;
          state_d   = bus.flush_i ? IDLE : FIX;
        end else if (bus.flush_i) begin
          cnt_clr = 1'b1;
          state_d = DRAIN;
        end else if (timeout) begin
          state_d = RESP;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      FIX:  state_d = bus.flush_i ? IDLE : RESP;
      RESP: if (bus.flush_i || bus.rsp_ready_i) state_d = IDLE;
      DRAIN: begin
        if (bus.mul_mulvalid_i) begin
          mul_ready = 1'b1;
          state_d   = IDLE;
        end else if (timeout) begin
          state_d = IDLE;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // The core only produces a signed product; unsigned forms add back the sign-bit terms.
  always_comb begin
    fix_data = '0;
    case (op_q)
      OP_MUL:    fix_data = lo_q;
      OP_MULH:   fix_data = hi_q;
      OP_MULHSU: fix_data = hi_q + (b_q[XLEN-1] ? a_q : '0);
      OP_MULHU:  fix_data = hi_q + (a_q[XLEN-1] ? b_q : '0) + (b_q[XLEN-1] ? a_q : '0);
      OP_MULW:   fix_data = {{(XLEN-32){lo_q[31]}}, lo_q[31:0]};
      default:   fix_data = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      a_q    <= '0;
      b_q    <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
      op_q   <= '0;
      tag_q  <= '0;
      data_q <= '0;
      err_q  <= 1'b0;
    end else begin
      if (cnt_clr)      cnt_q <= '0;
      else if (cnt_inc) cnt_q <= cnt_q + CNT_W'(1);
      case (state_q)
        IDLE: if (bus.req_valid_i) begin
          a_q    <= bus.req_rs1_i;
          b_q    <= bus.req_rs2_i;
          op_q   <= bus.req_op_i;
          tag_q  <= bus.req_tag_i;
          data_q <= '0;
          err_q  <= !req_legal;
        end
        WAIT: begin
          if (bus.mul_mulvalid_i) begin
            hi_q <= bus.result_hi_i;
            lo_q <= bus.result_lo_i;
          end else if (!bus.flush_i && timeout) begin
            data_q <= '0;
            err_q  <= 1'b1;
          end
        end
        FIX: begin
          data_q <= fix_data;
          err_q  <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign bus.req_ready_o     = (state_q == IDLE);
  assign bus.mul_datavaild_o = (state_q == ISSUE);
  assign bus.multiplicand_o  = a_q;
  assign bus.multiplier_o    = b_q;
  assign bus.mul_ready_o     = mul_ready;
  assign bus.rsp_valid_o     = (state_q == RESP);
  assign bus.rsp_data_o      = data_q;
  assign bus.rsp_tag_o       = tag_q;
  assign bus.rsp_err_o       = err_q;
endmodule

// File: tb/tb_mul_issue_ctrl.sv
// Directed bench for mul_issue_ctrl: a latency-programmable core model, an RV64M result
// model for the scoreboard, and per-cycle checks of the handshake outputs.
module tb_mul_issue_ctrl;
  localparam int XLEN = 64, TAG_W = 4, TIMEOUT = 16;

  typedef struct packed {
    logic [63:0]      data;
    logic [TAG_W-1:0] tag;
    logic             err;
  } rsp_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0, n_checks = 0, n_fail = 0;
  int   n_hs = 0, n_rsp_vld = 0, n_mrdy = 0, n_dv = 0;
  int   acc_cyc = 0;
  int   core_lat = 1, inject_req = 0;
  rsp_t exp_q[$];
  rsp_t last_rsp;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mul_issue_if #(.XLEN(XLEN), .TAG_W(TAG_W)) bus();
  mul_issue_ctrl #(.XLEN(XLEN), .TAG_W(TAG_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Architectural RV64M results computed directly from full-width products.
  function automatic logic [63:0] ref_result(input logic [2:0] op, input logic [63:0] a,
                                             input logic [63:0] b);
    logic [127:0] ss, su, uu;
    ss = $signed({{64{a[63]}}, a}) * $signed({{64{b[63]}}, b});
    su = $signed({{64{a[63]}}, a}) * $signed({64'h0, b});
    uu = {64'h0, a} * {64'h0, b};
    case (op)
      3'd0:    return ss[63:0];
      3'd1:    return ss[127:64];
      3'd2:    return su[127:64];
      3'd3:    return uu[127:64];
      3'd4:    return {{32{ss[31]}}, ss[31:0]};
      default: return 64'h0;
    endcase
  endfunction

  // Multiplier core: signed product after core_lat cycles (0 = never), held until mul_ready.
  initial begin
    logic         s_dv, s_rdy, pend;
    logic [63:0]  s_a, s_b;
    logic [127:0] prod;
    int           cd, seen;
    bus.mul_mulvalid_i = 1'b0;
    bus.result_hi_i    = '0;
    bus.result_lo_i    = '0;
    pend = 1'b0; cd = 0; seen = 0;
    forever begin
      @(negedge clk);
      s_dv  = bus.mul_datavaild_o;
      s_rdy = bus.mul_ready_o;
      s_a   = bus.multiplicand_o;
      s_b   = bus.multiplier_o;
      @(posedge clk); #1;
      if (s_rdy && bus.mul_mulvalid_i) bus.mul_mulvalid_i = 1'b0;
      if (s_dv) begin
        pend = (core_lat != 0);
        cd   = core_lat;
        prod = $signed({{64{s_a[63]}}, s_a}) * $signed({{64{s_b[63]}}, s_b});
      end
      if (pend) begin
        cd--;
        if (cd == 0) begin
          pend = 1'b0;
          bus.mul_mulvalid_i = 1'b1;
          bus.result_hi_i    = prod[127:64];
          bus.result_lo_i    = prod[63:0];
        end
      end
      if (inject_req != seen) begin
        seen = inject_req;
        bus.mul_mulvalid_i = 1'b1;
      end
    end
  end

  // Per-cycle compare: operand pulse follows each legal accept, responses match the
  // scoreboard at handshake, and a pending response is held stable.
  initial begin
    logic acc_prev, hold_prev;
    rsp_t cur, held, e;
    acc_prev = 1'b0; hold_prev = 1'b0; held = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        acc_prev  = 1'b0;
        hold_prev = 1'b0;
      end else begin
        check("dv_pulse", 64'(bus.mul_datavaild_o), 64'(acc_prev));
        acc_prev = bus.req_valid_i && bus.req_ready_o && (bus.req_op_i <= 3'd4);
        if (bus.mul_datavaild_o) n_dv++;
        if (bus.mul_ready_o) n_mrdy++;
        cur.data = bus.rsp_data_o;
        cur.tag  = bus.rsp_tag_o;
        cur.err  = bus.rsp_err_o;
        if (bus.rsp_valid_o) begin
          n_rsp_vld++;
          if (hold_prev) begin
            check("hold_data", cur.data, held.data);
            check("hold_tag", 64'(cur.tag), 64'(held.tag));
            check("hold_err", 64'(cur.err), 64'(held.err));
          end
          if (bus.rsp_ready_i && !bus.flush_i) begin
            n_hs++;
            last_rsp = cur;
            if (exp_q.size() == 0) begin
              check("unexpected_rsp", 64'(n_hs), 64'h0);
            end else begin
              e = exp_q.pop_front();
              check("rsp_data", cur.data, e.data);
              check("rsp_tag", 64'(cur.tag), 64'(e.tag));
              check("rsp_err", 64'(cur.err), 64'(e.err));
            end
          end
        end
        hold_prev = bus.rsp_valid_o && !bus.rsp_ready_i && !bus.flush_i;
        held = cur;
      end
    end
  end

  task automatic expect_model(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b,
                              input logic [TAG_W-1:0] tag);
    rsp_t e;
    e.data = ref_result(op, a, b);
    e.tag  = tag;
    e.err  = 1'b0;
    exp_q.push_back(e);
  endtask

  task automatic expect_err(input logic [TAG_W-1:0] tag);
    rsp_t e;
    e.data = '0;
    e.tag  = tag;
    e.err  = 1'b1;
    exp_q.push_back(e);
  endtask

  // Called just after a posedge; returns one cycle after the accepting edge.
  task automatic issue(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b,
                       input logic [TAG_W-1:0] tag);
    logic ok;
    bus.req_valid_i = 1'b1;
    bus.req_op_i    = op;
    bus.req_rs1_i   = a;
    bus.req_rs2_i   = b;
    bus.req_tag_i   = tag;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus.req_ready_o) begin ok = 1'b1; break; end
    end
    check("issue_accept", 64'(ok), 64'h1);
    acc_cyc = cyc;
    @(posedge clk); #1;
    bus.req_valid_i = 1'b0;
  endtask

  task automatic wait_vld(input int budget, output int lat);
    logic ok;
    ok = 1'b0;
    lat = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (bus.rsp_valid_o) begin ok = 1'b1; lat = cyc - acc_cyc; break; end
    end
    check("rsp_valid_seen", 64'(ok), 64'h1);
  endtask

  task automatic wait_hs(input int target, input int budget);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (n_hs >= target) begin ok = 1'b1; break; end
    end
    check("rsp_handshake_seen", 64'(ok), 64'h1);
    @(posedge clk); #1;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, h0, m0, r0, d0;
    logic ok;
    logic [63:0] ra, rb;
    rst = 1'b1;
    bus.req_valid_i = 1'b0;
    bus.req_op_i    = '0;
    bus.req_rs1_i   = '0;
    bus.req_rs2_i   = '0;
    bus.req_tag_i   = '0;
    bus.flush_i     = 1'b0;
    bus.rsp_ready_i = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_req_ready", 64'(bus.req_ready_o), 64'h1);
    check("rst_rsp_valid", 64'(bus.rsp_valid_o), 64'h0);
    check("rst_datavalid", 64'(bus.mul_datavaild_o), 64'h0);
    check("rst_mul_ready", 64'(bus.mul_ready_o), 64'h0);
    check("rst_rsp_data", bus.rsp_data_o, 64'h0);
    check("rst_rsp_tag", 64'(bus.rsp_tag_o), 64'h0);
    check("rst_rsp_err", 64'(bus.rsp_err_o), 64'h0);
    check("rst_multiplicand", bus.multiplicand_o, 64'h0);
    check("rst_multiplier", bus.multiplier_o, 64'h0);
    @(posedge clk); #1;
    rst = 1'b0;

    // MUL 3 * -5 with downstream stalled; latency 3 + core latency 1
    core_lat = 1;
    bus.rsp_ready_i = 1'b0;
    h0 = n_hs;
    expect_model(3'd0, 64'd3, 64'hFFFF_FFFF_FFFF_FFFB, 4'h5);
    issue(3'd0, 64'd3, 64'hFFFF_FFFF_FFFF_FFFB, 4'h5);
    wait_vld(20, lat);
    check("t1_latency", 64'(lat), 64'd4);
    repeat (3) @(negedge clk);
    @(posedge clk); #1;
    bus.rsp_ready_i = 1'b1;
    wait_hs(h0 + 1, 10);
    check("t1_mul_data", last_rsp.data, 64'hFFFF_FFFF_FFFF_FFF1);
    check("t1_mul_tag", 64'(last_rsp.tag), 64'h5);

    core_lat = 3;
    h0 = n_hs;
    expect_model(3'd3, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 4'h2);
    issue(3'd3, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 4'h2);
    wait_hs(h0 + 1, 30);
    check("t2_mulhu_data", last_rsp.data, 64'h0000_0000_0000_0001);
    check("t2_mulhu_err", 64'(last_rsp.err), 64'h0);

    core_lat = 2;
    h0 = n_hs;
    expect_model(3'd2, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 4'h3);
    issue(3'd2, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 4'h3);
    wait_hs(h0 + 1, 30);
    check("t3_mulhsu_data", last_rsp.data, 64'hFFFF_FFFF_FFFF_FFFF);

    core_lat = 1;
    h0 = n_hs;
    expect_model(3'd4, 64'h0000_0000_7FFF_FFFF, 64'd2, 4'h4);
    issue(3'd4, 64'h0000_0000_7FFF_FFFF, 64'd2, 4'h4);
    wait_hs(h0 + 1, 30);
    check("t4_mulw_data", last_rsp.data, 64'hFFFF_FFFF_FFFF_FFFE);

    // every op with mixed-sign operands against the model
    for (int i = 0; i < 10; i++) begin
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      if (i % 2 == 1) ra[63] = 1'b1;
      if (i % 3 == 1) rb[63] = 1'b1;
      core_lat = 1 + (i % 4);
      h0 = n_hs;
      expect_model(3'(i % 5), ra, rb, 4'(i));
      issue(3'(i % 5), ra, rb, 4'(i));
      wait_hs(h0 + 1, 30);
    end

    // flush during WAIT; core answers 4 cycles later into DRAIN
    core_lat = 5;
    m0 = n_mrdy; r0 = n_rsp_vld;
    issue(3'd0, 64'd7, 64'd9, 4'h7);
    @(posedge clk); #1;
    bus.flush_i = 1'b1;
    @(posedge clk); #1;
    bus.flush_i = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.mul_ready_o) begin ok = 1'b1; break; end
    end
    check("t5_drain_ready_seen", 64'(ok), 64'h1);
    @(negedge clk);
    check("t5_req_ready_after", 64'(bus.req_ready_o), 64'h1);
    repeat (2) @(negedge clk);
    check("t5_mul_ready_pulses", 64'(n_mrdy - m0), 64'd1);
    check("t5_no_rsp_valid", 64'(n_rsp_vld - r0), 64'd0);
    @(posedge clk); #1;

    // flush in RESP beats rsp_ready in the same cycle
    core_lat = 1;
    bus.rsp_ready_i = 1'b0;
    h0 = n_hs;
    issue(3'd1, 64'd11, 64'd13, 4'h6);
    wait_vld(20, lat);
    @(posedge clk); #1;
    bus.flush_i = 1'b1;
    bus.rsp_ready_i = 1'b1;
    @(posedge clk); #1;
    bus.flush_i = 1'b0;
    @(negedge clk);
    check("t5b_rsp_dropped", 64'(bus.rsp_valid_o), 64'h0);
    check("t5b_req_ready", 64'(bus.req_ready_o), 64'h1);
    check("t5b_no_handshake", 64'(n_hs - h0), 64'd0);
    @(posedge clk); #1;

    // illegal op: error response, core untouched
    h0 = n_hs; d0 = n_dv;
    expect_err(4'hA);
    issue(3'd5, 64'd1, 64'd1, 4'hA);
    wait_hs(h0 + 1, 20);
    check("t6_illegal_err", 64'(last_rsp.err), 64'h1);
    check("t6_illegal_data", last_rsp.data, 64'h0);
    check("t6_no_datavalid", 64'(n_dv - d0), 64'd0);

    // silent core: timeout error after 16 WAIT cycles, then a stale valid in IDLE
    core_lat = 0;
    h0 = n_hs;
    expect_err(4'h9);
    issue(3'd0, 64'd5, 64'd6, 4'h9);
    wait_vld(40, lat);
    check("t6_timeout_latency", 64'(lat), 64'd18);
    wait_hs(h0 + 1, 10);
    check("t6_timeout_err", 64'(last_rsp.err), 64'h1);
    check("t6_timeout_tag", 64'(last_rsp.tag), 64'h9);
    m0 = n_mrdy; r0 = n_rsp_vld;
    inject_req++;
    repeat (5) @(negedge clk);
    check("t6_stale_ready_pulses", 64'(n_mrdy - m0), 64'd1);
    check("t6_stale_no_rsp", 64'(n_rsp_vld - r0), 64'd0);
    check("t6_stale_consumed", 64'(bus.mul_mulvalid_i), 64'h0);
    @(posedge clk); #1;

    // reset mid-WAIT; the late core result is absorbed as stale
    core_lat = 6;
    issue(3'd0, 64'd21, 64'd2, 4'h1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    m0 = n_mrdy; r0 = n_rsp_vld;
    @(negedge clk);
    check("t7_req_ready", 64'(bus.req_ready_o), 64'h1);
    check("t7_rsp_valid", 64'(bus.rsp_valid_o), 64'h0);
    check("t7_operand_cleared", bus.multiplicand_o, 64'h0);
    repeat (8) @(negedge clk);
    check("t7_stale_ready_pulses", 64'(n_mrdy - m0), 64'd1);
    check("t7_no_rsp", 64'(n_rsp_vld - r0), 64'd0);

    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
